// File: rtl/dmarb_pkg.sv
// Shared types for the two-port data memory arbiter: FSM states, port ids, latched command.
package dmarb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } dmarb_state_t;

    localparam int PORT_CPU = 0;
    localparam int PORT_DMA = 1;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmarb_cmd_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker; zero latency, no backpressure of its own.
// On contention the port that did not win last time is granted.
module rr_pick2
    import dmarb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    assign gnt_valid = |req;
    assign gnt_idx   = (req == 2'b11) ? ~last : req[PORT_DMA];

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one single-port data memory between CPU (port 0) and DMA (port 1); 3-cycle access.
// Requesters hold req until a one-cycle ack; the loser simply keeps waiting its turn.
module data_mem_arbiter
    import dmarb_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_i,
    input  logic [1:0]  we_i,
    input  logic [63:0] addr_i,
    input  logic [63:0] wdata_i,
    output logic [1:0]  ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rd
);

    dmarb_state_t state_q, state_d;
    dmarb_cmd_t   cmd_q;
    logic         win_q;
    logic         last_q;
    logic [31:0]  rdata_q;
    logic         err_q;
    logic         gnt_valid;
    logic         gnt_idx;
    logic         ok;

    rr_pick2 u_pick (
        .req       (req_i),
        .last      (last_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // High address bits are checked rather than truncated, so nothing aliases into the array.
    assign ok = (cmd_q.addr[1:0] == 2'b00) && (cmd_q.addr[31:ADDR_W+2] == '0);

    assign mem_addr  = {{(32-ADDR_W){1'b0}}, cmd_q.addr[ADDR_W+1:2]};
    assign mem_wdata = cmd_q.wdata;
    assign rdata_o   = rdata_q;
    assign err_o     = err_q;

    always_comb begin
        state_d = state_q;
        ack_o   = 2'b00;
        mem_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gnt_valid) state_d = ACCESS;
            end
            ACCESS: begin
                mem_we  = cmd_q.we & ok;
                state_d = RESP;
            end
            RESP: begin
                ack_o[win_q] = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            win_q   <= 1'b0;
            last_q  <= 1'b1;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && gnt_valid) begin
                win_q       <= gnt_idx;
                last_q      <= gnt_idx;
                cmd_q.we    <= we_i[gnt_idx];
                cmd_q.addr  <= gnt_idx ? addr_i[63:32]  : addr_i[31:0];
                cmd_q.wdata <= gnt_idx ? wdata_i[63:32] : wdata_i[31:0];
            end
            if (state_q == ACCESS) begin
                rdata_q <= (cmd_q.we || !ok) ? 32'd0 : mem_rd;
                err_q   <= !ok;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: behavioural 64-word memory plus scoreboard of expected responses.
module tb_data_mem_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req_i;
    logic [1:0]  we_i;
    logic [63:0] addr_i;
    logic [63:0] wdata_i;
    logic [1:0]  ack_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rd;

    data_mem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req_i),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .ack_o     (ack_o),
        .rdata_o   (rdata_o),
        .err_o     (err_o),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    assign mem_rd = mem[mem_addr[5:0]];
    always @(posedge clk) if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          port;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   exp_last = 1;

    task automatic predict(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
        logic ok;
        exp_t e;
        ok      = (a[1:0] == 2'b00) && (a[31:8] == 24'd0);
        e.port  = p;
        e.err   = !ok;
        e.rdata = (we || !ok) ? 32'd0 : ref_mem[a[7:2]];
        sb.push_back(e);
        if (we && ok) ref_mem[a[7:2]] = d;
    endtask

    task automatic issue(input int p, input logic we, input logic [31:0] a, input logic [31:0] d,
                         output logic [1:0] ack, output logic [31:0] rd, output logic er,
                         output logic [31:0] acc_addr, output logic we_seen, output logic to);
        predict(p, we, a, d);
        @(negedge clk);
        req_i[p]            = 1'b1;
        we_i[p]             = we;
        addr_i[p*32 +: 32]  = a;
        wdata_i[p*32 +: 32] = d;
        ack = 2'b00; rd = '0; er = 1'b0; acc_addr = '0; we_seen = 1'b0; to = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack_o != 2'b00) begin
                ack = ack_o; rd = rdata_o; er = err_o; to = 1'b0;
                break;
            end
            acc_addr = mem_addr;
            we_seen  = we_seen | mem_we;
        end
        req_i[p] = 1'b0;
        exp_last = p;
    endtask

    task automatic test_reset;
        n_checks++; if (ack_o !== 2'b00) $display("FAIL reset_ack: got %b expected 00", ack_o); else n_pass++;
        n_checks++; if (rdata_o !== 32'd0) $display("FAIL reset_rdata: got %h expected 0", rdata_o); else n_pass++;
        n_checks++; if (err_o !== 1'b0) $display("FAIL reset_err: got %b expected 0", err_o); else n_pass++;
        n_checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b expected 0", mem_we); else n_pass++;
        n_checks++; if (mem_addr !== 32'd0) $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); else n_pass++;
        n_checks++; if (mem_wdata !== 32'd0) $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); else n_pass++;
    endtask

    task automatic test_reset_mid_access;
        logic seen;
        @(negedge clk);
        req_i = 2'b01; we_i = 2'b01; addr_i[31:0] = 32'h10; wdata_i[31:0] = 32'hAA;
        @(negedge clk);
        n_checks++; if (mem_we !== 1'b1) $display("FAIL rst_mid_we_before: got %b expected 1", mem_we); else n_pass++;
        #1 reset = 1'b1;
        #1;
        n_checks++; if (mem_we !== 1'b0) $display("FAIL rst_mid_we_drop: got %b expected 0", mem_we); else n_pass++;
        n_checks++; if (ack_o !== 2'b00) $display("FAIL rst_mid_ack: got %b expected 00", ack_o); else n_pass++;
        @(negedge clk);
        req_i = 2'b00; we_i = 2'b00; reset = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ack_o != 2'b00) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL rst_mid_lost_ack: got %b expected 0", seen); else n_pass++;
        n_checks++; if (mem[4] !== ref_mem[4]) $display("FAIL rst_mid_word4: got %h expected %h", mem[4], ref_mem[4]); else n_pass++;
        exp_last = 1;
    endtask

    task automatic test_store_load;
        logic [1:0] ack; logic [31:0] rd, aa; logic er, ws, to;
        exp_t e;
        issue(0, 1'b1, 32'h08, 32'hDEADBEEF, ack, rd, er, aa, ws, to);
        e = sb.pop_front();
        n_checks++; if (to !== 1'b0) $display("FAIL st_timeout: got %b expected 0", to); else n_pass++;
        n_checks++; if (ack !== 2'b01) $display("FAIL st_ack: got %b expected 01", ack); else n_pass++;
        n_checks++; if (er !== e.err || rd !== e.rdata) $display("FAIL st_resp: got err=%b rdata=%h expected err=%b rdata=%h", er, rd, e.err, e.rdata); else n_pass++;
        n_checks++; if (aa !== 32'd2) $display("FAIL st_mem_addr: got %h expected 2", aa); else n_pass++;
        n_checks++; if (ws !== 1'b1) $display("FAIL st_mem_we: got %b expected 1", ws); else n_pass++;
        issue(0, 1'b0, 32'h08, 32'h0, ack, rd, er, aa, ws, to);
        e = sb.pop_front();
        n_checks++; if (to !== 1'b0 || ack !== 2'b01) $display("FAIL ld_ack: got %b expected 01", ack); else n_pass++;
        n_checks++; if (rd !== e.rdata) $display("FAIL ld_rdata: got %h expected %h", rd, e.rdata); else n_pass++;
        n_checks++; if (er !== 1'b0) $display("FAIL ld_err: got %b expected 0", er); else n_pass++;
        n_checks++; if (aa !== 32'd2 || ws !== 1'b0) $display("FAIL ld_access: got addr=%h we=%b expected addr=2 we=0", aa, ws); else n_pass++;
    endtask

    task automatic test_alternation;
        logic [31:0] a0, a1;
        logic [1:0]  exp_ack;
        logic        got;
        int          w, t_prev;
        exp_t        e;
        a0 = 32'h20; a1 = 32'h24;
        w  = exp_last;
        for (int k = 0; k < 4; k++) begin
            w = 1 - w;
            predict(w, 1'b0, (w == 1) ? a1 : a0, 32'd0);
        end
        @(negedge clk);
        req_i = 2'b11; we_i = 2'b00; addr_i = {a1, a0};
        t_prev = 0;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (ack_o != 2'b00) begin got = 1'b1; break; end
            end
            e = sb.pop_front();
            exp_ack = (e.port == 1) ? 2'b10 : 2'b01;
            n_checks++; if (got !== 1'b1 || ack_o !== exp_ack) $display("FAIL rr_grant%0d: got %b expected %b", k, ack_o, exp_ack); else n_pass++;
            n_checks++; if (rdata_o !== e.rdata || err_o !== 1'b0) $display("FAIL rr_rdata%0d: got %h/%b expected %h/0", k, rdata_o, err_o, e.rdata); else n_pass++;
            if (k > 0) begin
                n_checks++; if (cyc - t_prev !== 3) $display("FAIL rr_spacing%0d: got %0d expected 3", k, cyc - t_prev); else n_pass++;
            end
            t_prev = cyc;
        end
        req_i = 2'b00;
        exp_last = w;
    endtask

    task automatic test_out_of_range;
        logic [1:0] ack; logic [31:0] rd, aa; logic er, ws, to;
        exp_t e;
        issue(1, 1'b1, 32'h100, 32'h55AA55AA, ack, rd, er, aa, ws, to);
        e = sb.pop_front();
        n_checks++; if (to !== 1'b0 || ack !== 2'b10) $display("FAIL oor_ack: got %b expected 10", ack); else n_pass++;
        n_checks++; if (er !== e.err) $display("FAIL oor_err: got %b expected %b", er, e.err); else n_pass++;
        n_checks++; if (rd !== 32'd0) $display("FAIL oor_rdata: got %h expected 0", rd); else n_pass++;
        n_checks++; if (ws !== 1'b0) $display("FAIL oor_mem_we: got %b expected 0", ws); else n_pass++;
        n_checks++; if (mem[0] !== ref_mem[0]) $display("FAIL oor_word0: got %h expected %h", mem[0], ref_mem[0]); else n_pass++;
    endtask

    task automatic test_misaligned;
        logic [1:0] ack; logic [31:0] rd, aa; logic er, ws, to;
        exp_t e;
        issue(0, 1'b0, 32'h06, 32'h0, ack, rd, er, aa, ws, to);
        e = sb.pop_front();
        n_checks++; if (to !== 1'b0 || ack !== 2'b01) $display("FAIL mis_ack: got %b expected 01", ack); else n_pass++;
        n_checks++; if (er !== e.err || er !== 1'b1) $display("FAIL mis_err: got %b expected 1", er); else n_pass++;
        n_checks++; if (rd !== e.rdata) $display("FAIL mis_rdata: got %h expected %h", rd, e.rdata); else n_pass++;
    endtask

    task automatic test_top_boundary;
        logic [1:0] ack; logic [31:0] rd, aa; logic er, ws, to;
        exp_t e;
        issue(1, 1'b1, 32'hFC, 32'hCAFEF00D, ack, rd, er, aa, ws, to);
        e = sb.pop_front();
        n_checks++; if (to !== 1'b0 || ack !== 2'b10 || er !== e.err) $display("FAIL top_st: got ack=%b err=%b expected ack=10 err=%b", ack, er, e.err); else n_pass++;
        n_checks++; if (aa !== 32'd63) $display("FAIL top_mem_addr: got %h expected 3f", aa); else n_pass++;
        n_checks++; if (mem[63] !== ref_mem[63]) $display("FAIL top_word63: got %h expected %h", mem[63], ref_mem[63]); else n_pass++;
        issue(1, 1'b0, 32'hFC, 32'h0, ack, rd, er, aa, ws, to);
        e = sb.pop_front();
        n_checks++; if (to !== 1'b0 || ack !== 2'b10) $display("FAIL top_ld_ack: got %b expected 10", ack); else n_pass++;
        n_checks++; if (rd !== e.rdata || er !== 1'b0) $display("FAIL top_ld: got %h/%b expected %h/0", rd, er, e.rdata); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 32'h1000_0000 + i;
            ref_mem[i] = 32'h1000_0000 + i;
        end
        reset = 1'b1; req_i = 2'b00; we_i = 2'b00; addr_i = '0; wdata_i = '0;
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b0;
        test_reset_mid_access();
        test_store_load();
        test_alternation();
        test_out_of_range();
        test_misaligned();
        test_top_boundary();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
